// File: rtl/hex_seq_ctrl_if.sv
// Pin bundle for the hex sequence controller: control inputs and display outputs.
// clk (io_in[0]) and rst_n (io_in[1]) are kept as plain scalar ports on the module,
// so only io_in[7:2] is carried here.
interface hex_seq_ctrl_if;
  // [2] run, [3] step, [4] dir, [5] clear, [7:6] rate_sel
  logic [7:2] io_in;
  // [6:0] segments a..g (bit0 = a), [7] tick
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/hex_seq_ctrl.sv
// Run/pause/step controller driving a hex digit on a seven-segment display.
// Latency: inputs act at the 3rd clock edge after they change; segments are combinational from the count.
// Backpressure: none, pin-level block; every synchronised input is consumed on the cycle it arrives.
module hex_seq_ctrl #(
  parameter int BASE_DIV  = 4,   // base tick period in clocks, period = BASE_DIV << rate_sel
  parameter int MAX_COUNT = 15,  // wrap limit of the count, 1..15
  parameter int PRE_W     = 10   // prescaler width, must hold (BASE_DIV << 3) - 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  hex_seq_ctrl_if.slave pins
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0]       MAX_C  = 4'(MAX_COUNT);
  localparam logic [PRE_W-1:0] BASE_W = PRE_W'(BASE_DIV);

  // Synchroniser chain: two flops on every control input, a third on step for edge detection.
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic       step3_q;

  // FSM, counter and output registers.
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;

  // Synchronised views of the pins.
  logic             run_s;
  logic             step_s;
  logic             dir_s;
  logic             clear_s;
  logic [1:0]       rate_s;
  logic             step_pulse;
  logic [PRE_W-1:0] period_m1;
  logic             adv;
  logic [6:0]       seg;

  assign run_s      = sync2_q[0];
  assign step_s     = sync2_q[1];
  assign dir_s      = sync2_q[2];
  assign clear_s    = sync2_q[3];
  assign rate_s     = sync2_q[5:4];
  assign step_pulse = step_s & ~step3_q;

  // Terminal prescaler value for the currently selected rate.
  assign period_m1 = (BASE_W << rate_s) - PRE_W'(1);

  // One advance in the chosen direction, wrapping between 0 and MAX_COUNT.
  function automatic logic [3:0] next_count(input logic [3:0] c, input logic up);
    if (up) begin
      return (c == MAX_C) ? 4'd0 : c + 4'd1;
    end
    return (c == 4'd0) ? MAX_C : c - 4'd1;
  endfunction

  // Bring the asynchronous pins into the clock domain and delay step once more for the edge detect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      step3_q <= 1'b0;
    end else begin
      sync1_q <= pins.io_in;
      sync2_q <= sync1_q;
      step3_q <= sync2_q[1];
    end
  end

  // State, count, prescaler and tick registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  // Next state: clear wins, then the RUN prescaler, then a manual step outside RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    adv     = 1'b0;
    if (clear_s) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      pre_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!run_s) begin
            // Leaving RUN takes priority over a coinciding prescaler expiry.
            state_d = ST_PAUSE;
            pre_d   = '0;
          end else if (pre_q >= period_m1) begin
            // >= so that a rate decrease mid-period fires on the next clock.
            adv   = 1'b1;
            pre_d = '0;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        default: begin
          // IDLE and PAUSE: prescaler parked at 0 so the first run tick is a full period away.
          pre_d = '0;
          if (step_pulse) begin
            adv = 1'b1;
          end
          if (run_s) begin
            state_d = ST_RUN;
          end
        end
      endcase
      if (adv) begin
        cnt_d = next_count(cnt_q, dir_s);
      end
    end
  end

  assign tick_d = adv;

  // Hex to seven-segment decode, segment a in bit 0, active-high.
  always_comb begin
    seg = 7'h3F;
    case (cnt_q)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h3F;
    endcase
  end

  assign pins.io_out = {tick_q, seg};

endmodule

// File: tb/tb_hex_seq_ctrl.sv
// Bench for hex_seq_ctrl: reference model compared every cycle, a step table,
// hand sequences for reset, wrap, step, clear and rate-change corners, then random stimulus.
module tb_hex_seq_ctrl;

  localparam int BASE_DIV = 4;
  localparam int MAXC     = 15;

  logic clk;
  logic rst_n;
  logic in_run, in_step, in_dir, in_clr;
  logic [1:0] in_rate;

  hex_seq_ctrl_if bus ();
  hex_seq_ctrl_if bus9 ();

  assign bus.io_in  = {in_rate, in_clr, in_dir, in_step, in_run};
  assign bus9.io_in = {in_rate, in_clr, in_dir, in_step, in_run};

  hex_seq_ctrl #(.BASE_DIV(BASE_DIV), .MAX_COUNT(MAXC), .PRE_W(10)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .pins    (bus)
  );

  hex_seq_ctrl #(.BASE_DIV(BASE_DIV), .MAX_COUNT(9), .PRE_W(10)) dut9 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .pins    (bus9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int errs   = 0;
  int tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 pause; inputs seen through a history of applied values.
  int         m_mode, m_cnt, m_el;
  logic       m_tick;
  logic [5:0] hist[$];

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_el = 0; m_tick = 1'b0;
    hist = '{6'd0, 6'd0, 6'd0, 6'd0};
  endtask

  task automatic model_adv(input logic up);
    m_cnt  = up ? (m_cnt + 1) % (MAXC + 1) : (m_cnt + MAXC) % (MAXC + 1);
    m_tick = 1'b1;
  endtask

  task automatic model_edge();
    logic [5:0] e, p;
    int period;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_front({in_rate, in_clr, in_dir, in_step, in_run});
    e = hist[2];
    p = hist[3];
    void'(hist.pop_back());
    m_tick = 1'b0;
    period = BASE_DIV << e[5:4];
    if (e[3]) begin
      m_mode = 0; m_cnt = 0; m_el = 0;
    end else if (m_mode == 1) begin
      if (!e[0]) begin
        m_mode = 2; m_el = 0;
      end else begin
        m_el++;
        if (m_el >= period) begin
          model_adv(e[2]);
          m_el = 0;
        end
      end
    end else begin
      if (e[1] && !p[1]) model_adv(e[2]);
      if (e[0]) begin
        m_mode = 1; m_el = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("model_out", {24'd0, bus.io_out}, {24'd0, m_tick, segtab[m_cnt]});
    if (bus.io_out[7]) tick_cnt++;
  endtask

  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (bus.io_out[7]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic step_pulse();
    in_step = 1'b1;
    cyc(); cyc();
    in_step = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  typedef struct {
    logic       dir;
    int         nsteps;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n, t0;
    bit found;

    // Cumulative from count 0, MAX_COUNT 15.
    tbl[0]  = '{1'b1, 5,  7'h6D};  // 5
    tbl[1]  = '{1'b0, 7,  7'h79};  // E
    tbl[2]  = '{1'b1, 2,  7'h3F};  // 0
    tbl[3]  = '{1'b0, 1,  7'h71};  // F
    tbl[4]  = '{1'b1, 11, 7'h77};  // A
    tbl[5]  = '{1'b1, 1,  7'h7C};  // b
    tbl[6]  = '{1'b1, 1,  7'h39};  // C
    tbl[7]  = '{1'b1, 1,  7'h5E};  // d
    tbl[8]  = '{1'b0, 4,  7'h6F};  // 9
    tbl[9]  = '{1'b0, 1,  7'h7F};  // 8
    tbl[10] = '{1'b0, 1,  7'h07};  // 7
    tbl[11] = '{1'b0, 5,  7'h5B};  // 2
    tbl[12] = '{1'b1, 1,  7'h4F};  // 3
    tbl[13] = '{1'b1, 1,  7'h66};  // 4
    tbl[14] = '{1'b1, 2,  7'h7D};  // 6
    tbl[15] = '{1'b0, 5,  7'h06};  // 1

    in_run = 0; in_step = 0; in_dir = 1; in_clr = 0; in_rate = 2'd0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out", {24'd0, bus.io_out}, 32'h3F);
    check("reset_out9", {24'd0, bus9.io_out}, 32'h3F);
    cyc(); cyc(); cyc();
    rst_n = 1'b1;

    // Free run at base rate: first tick 3 sync clocks + 4, then every 4, 0..F and wrap.
    in_run = 1'b1;
    wait_tick(20, n);
    check("first_tick_lat", n, 7);
    for (int i = 2; i <= 17; i++) begin
      wait_tick(10, n);
      check("run_gap", n, 4);
      check("run_seq", {25'd0, bus.io_out[6:0]}, {25'd0, segtab[i % 16]});
    end

    // Mid-run reset at count 5 clears the display asynchronously.
    repeat (4) wait_tick(10, n);
    check("count5", {25'd0, bus.io_out[6:0]}, 32'h6D);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {24'd0, bus.io_out}, 32'h3F);
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    wait_tick(20, n);
    check("rst_release_lat", n, 7);

    // Pause, clear to 0, then step down: wraps to MAX_COUNT in both builds.
    in_run = 1'b0; in_clr = 1'b1;
    repeat (4) cyc();
    in_clr = 1'b0;
    repeat (3) cyc();
    check("cleared", {25'd0, bus.io_out[6:0]}, 32'h3F);
    in_dir = 1'b0;
    step_pulse();
    check("down_wrap", {25'd0, bus.io_out[6:0]}, 32'h71);
    check("down_wrap9", {25'd0, bus9.io_out[6:0]}, 32'h6F);
    in_dir = 1'b1;
    step_pulse();
    check("up_wrap", {25'd0, bus.io_out[6:0]}, 32'h3F);
    check("up_wrap9", {25'd0, bus9.io_out[6:0]}, 32'h3F);

    // Table of step sequences while idle.
    for (int i = 0; i < 16; i++) begin
      in_dir = tbl[i].dir;
      t0 = tick_cnt;
      repeat (tbl[i].nsteps) step_pulse();
      check("tbl_seg", {25'd0, bus.io_out[6:0]}, {25'd0, tbl[i].exp_seg});
      check("tbl_ticks", tick_cnt - t0, tbl[i].nsteps);
    end

    // Three steps plus one held step: exactly four advances.
    in_dir = 1'b1;
    t0 = tick_cnt;
    repeat (3) step_pulse();
    in_step = 1'b1;
    repeat (20) cyc();
    in_step = 1'b0;
    repeat (4) cyc();
    check("held_step_ticks", tick_cnt - t0, 4);
    check("held_step_seg", {25'd0, bus.io_out[6:0]}, 32'h6D);

    // Steps during RUN at the slowest rate are ignored.
    in_run = 1'b1; in_rate = 2'd3;
    repeat (3) cyc();
    t0 = tick_cnt;
    repeat (4) step_pulse();
    check("step_in_run", tick_cnt - t0, 0);

    // Rate drop 3 -> 0 with the prescaler at 10: next clock advances, then every 4.
    wait_tick(64, n);
    check("rate3_tick_seen", {31'd0, n > 0}, 32'd1);
    repeat (8) cyc();
    in_rate = 2'd0;
    wait_tick(10, n);
    check("rate_drop_lat", n, 3);
    wait_tick(10, n);
    check("rate_drop_gap", n, 4);

    // Clear while running at count 7: zero, no tick, held idle, run resumes after release.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_tick(10, n);
      if (bus.io_out[6:0] == 7'h07) found = 1;
    end
    check("reach7", {31'd0, found}, 32'd1);
    in_clr = 1'b1;
    t0 = tick_cnt;
    repeat (3) cyc();
    check("clear_zero", {24'd0, bus.io_out}, 32'h3F);
    repeat (10) cyc();
    check("clear_no_tick", tick_cnt - t0, 0);
    check("clear_held", {24'd0, bus.io_out}, 32'h3F);
    in_clr = 1'b0;
    wait_tick(20, n);
    check("clear_release_lat", n, 7);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) in_run = ~in_run;
      if ($urandom_range(5) == 0) in_step = ~in_step;
      if ($urandom_range(29) == 0) in_dir = ~in_dir;
      if (in_clr) begin
        if ($urandom_range(3) == 0) in_clr = 1'b0;
      end else if ($urandom_range(149) == 0) begin
        in_clr = 1'b1;
      end
      if ($urandom_range(49) == 0) in_rate = 2'($urandom_range(3));
      rst_n = (i % 1000 == 500) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
